mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one DDR memory-side port (read-request / write-data handshake pair plus returned read bursts) between NUM_PORTS cache-side requesters.
- Read requests and write requests are arbitrated independently by round-robin.
- An in-order tag queue routes each returned 8-word read burst back to the port that issued it.
- Sits in the 300 MHz domain, directly upstream of the DDR interface block.

Parameters:
NUM_PORTS, 4, number of requesters (2..8)
PORT_BITS, 2, clog2(NUM_PORTS), width of port ID
MAX_OUTSTANDING, 4, depth of the read tag queue (power of 2)
CNT_BITS, 16, width of optional statistics counters

Ports:
i_clk  in  1  clock (300 MHz domain)
i_reset_n  in  1  asynchronous active-low reset
i_rd_req  in  NUM_PORTS  per-port read request, held until accepted
i_rd_addr  in  NUM_PORTS*MEM_ADDRBITS  per-port read address, port p at slice p
o_rd_accept  out  NUM_PORTS  one-hot read-request accept
o_rd_data  out  MEM_WIDTH  shared returned read data
o_rd_valid  out  NUM_PORTS  one-hot; o_rd_data valid for that port
o_rd_lastword  out  1  marks the final word of the burst
i_wr_have  in  NUM_PORTS  per-port write pending
i_wr_addr  in  NUM_PORTS*MEM_ADDRBITS  per-port write address
i_wr_data  in  NUM_PORTS*MEM_WIDTH  per-port write data
o_wr_accept  out  NUM_PORTS  one-hot write accept
o_mem_raddr  out  MEM_ADDRBITS  to memory port
o_mem_rdata_req  out  1  to memory port
i_mem_rdata_req_accepted  in  1  from memory port
o_mem_waddr  out  MEM_ADDRBITS  to memory port
o_mem_wdata  out  MEM_WIDTH  to memory port
o_mem_wdata_have  out  1  to memory port
i_mem_wdata_accept  in  1  from memory port
i_mem_rdata  in  MEM_WIDTH  from memory port
i_mem_rdata_valid  in  1  from memory port
i_mem_rdata_lastword  in  1  from memory port
o_err_orphan  out  1  sticky: read data arrived with no outstanding tag

Behaviour:
- Reset (async, i_reset_n=0): read and write RR pointers = 0, tag queue empty, o_err_orphan=0; all one-hot outputs and o_mem_* request/have outputs read 0.
- Read arbitration (combinational from registered pointer):
  - Winner = first port p with i_rd_req[p]=1, searching from rd_ptr upward with wrap.
  - o_mem_rdata_req = any request && tag queue not full.
  - o_mem_raddr = winner's address; value is don't-care when no request.
  - o_rd_accept[winner] = i_mem_rdata_req_accepted && o_mem_rdata_req.
  - On accept: push winner ID into tag queue; rd_ptr <= winner+1 mod NUM_PORTS.
  - Pointer is unchanged when nothing is accepted.
- Tag queue full: o_mem_rdata_req=0 and no accepts; requests stay pending.
- Write arbitration: identical RR scheme with its own wr_ptr.
  - o_mem_wdata_have = any i_wr_have.
  - Address and data come from the winner.
  - o_wr_accept[winner] = i_mem_wdata_accept.
  - No tracking; zero added latency.
- Return path, combinational, no added latency:
  - When i_mem_rdata_valid=1 and the queue is non-empty: o_rd_valid[head]=1, o_rd_data=i_mem_rdata, o_rd_lastword=i_mem_rdata_lastword.
  - Head pops on the lastword beat.
- Push and pop in the same cycle: both occur; occupancy is unchanged; the pop uses the old head.
- Full queue with a simultaneous pop: no new push that cycle, because the full gate uses registered occupancy.
- Valid beat with an empty queue: beat is dropped, o_rd_valid=0, o_err_orphan<=1 until reset.
- Ordering: the memory port returns bursts in request order. Read-after-write hazards are the requesters' responsibility.
- Reset mid-burst: queue is cleared; remaining beats are orphans and set o_err_orphan.
- No combinational path from i_rd_req or i_wr_have to the pointers except through accept.

Optional Feature:
MEM_ARB_STATS_EN
- Defined: adds output o_stat_rd_grants [NUM_PORTS*CNT_BITS] and o_stat_wr_grants [NUM_PORTS*CNT_BITS].
  - Per-port saturating counters increment on each accept.
  - Counters clear on reset.
  - They hold at all-ones when saturated.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- defs.vh gains: ARB_NUM_PORTS, ARB_PORT_BITS, ARB_MAX_OUTSTANDING; existing MEM_ADDRBITS and MEM_WIDTH are reused.
- Sub-module rr_arbiter (NUM_PORTS, PORT_BITS):
  - Inputs: request vector, advance strobe.
  - Outputs: winner index, any-request.
  - Owns the registered pointer.
  - Instantiated twice, once for read and once for write.
- The tag queue is a small register FIFO written inline.

Test Plan:
- Ports 0 and 2 both raise i_rd_req with accept tied to 1 → accepts in order 0,2,0,2. Then port 3 alone → accepted next cycle, and rd_ptr wraps to 0.
- Issue 4 reads (ports 1,3,0,2) with no data returned → 5th request sees o_mem_rdata_req=0. Return 4 bursts of 8 beats → o_rd_valid asserts for ports 1,3,0,2 in order, with lastword on beat 8 of each.
- Lastword beat of burst 1 coincides with a new read accept while the queue is full → no accept that cycle; the next cycle accepts and occupancy returns to 4.
- i_wr_have on all 4 ports with i_mem_wdata_accept toggling 1,0,1,... → o_wr_accept goes 0,-,1,-,2,-,3; the data and address matching each grant appear on o_mem_*.
- Valid beat with the queue empty → no o_rd_valid and o_err_orphan=1. Assert i_reset_n=0 mid-burst → all outputs return to 0 and o_err_orphan clears.
- With MEM_ARB_STATS_EN: 70000 read accepts on port 0 → o_stat_rd_grants[0]=16'hFFFF while the other ports read 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths and defaults for the DDR port arbiter
package mem_port_arbiter_pkg;

    localparam int MEM_ADDRBITS        = 28;
    localparam int MEM_WIDTH           = 32;
    localparam int ARB_NUM_PORTS       = 4;
    localparam int ARB_PORT_BITS       = 2;
    localparam int ARB_MAX_OUTSTANDING = 4;
    localparam int ARB_CNT_BITS        = 16;
    localparam int ARB_BURST_BEATS     = 8;

    function automatic int tag_index_bits(int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - cache-side and memory-side signal bundle for mem_port_arbiter
// MEM_ARB_STATS_EN adds the per-port grant counter outputs.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = ARB_NUM_PORTS,
    parameter int CNT_BITS  = ARB_CNT_BITS
) ();

    logic [NUM_PORTS-1:0]              i_rd_req;
    logic [NUM_PORTS*MEM_ADDRBITS-1:0] i_rd_addr;
    logic [NUM_PORTS-1:0]              o_rd_accept;
    logic [MEM_WIDTH-1:0]              o_rd_data;
    logic [NUM_PORTS-1:0]              o_rd_valid;
    logic                              o_rd_lastword;
    logic [NUM_PORTS-1:0]              i_wr_have;
    logic [NUM_PORTS*MEM_ADDRBITS-1:0] i_wr_addr;
    logic [NUM_PORTS*MEM_WIDTH-1:0]    i_wr_data;
    logic [NUM_PORTS-1:0]              o_wr_accept;
    logic [MEM_ADDRBITS-1:0]           o_mem_raddr;
    logic                              o_mem_rdata_req;
    logic                              i_mem_rdata_req_accepted;
    logic [MEM_ADDRBITS-1:0]           o_mem_waddr;
    logic [MEM_WIDTH-1:0]              o_mem_wdata;
    logic                              o_mem_wdata_have;
    logic                              i_mem_wdata_accept;
    logic [MEM_WIDTH-1:0]              i_mem_rdata;
    logic                              i_mem_rdata_valid;
    logic                              i_mem_rdata_lastword;
    logic                              o_err_orphan;
`ifdef MEM_ARB_STATS_EN
    logic [NUM_PORTS*CNT_BITS-1:0]     o_stat_rd_grants;
    logic [NUM_PORTS*CNT_BITS-1:0]     o_stat_wr_grants;
`endif

    modport master (
        input  i_rd_req, i_rd_addr, i_wr_have, i_wr_addr, i_wr_data,
        input  i_mem_rdata_req_accepted, i_mem_wdata_accept,
        input  i_mem_rdata, i_mem_rdata_valid, i_mem_rdata_lastword,
        output o_rd_accept, o_rd_data, o_rd_valid, o_rd_lastword, o_wr_accept,
        output o_mem_raddr, o_mem_rdata_req, o_mem_waddr, o_mem_wdata, o_mem_wdata_have,
        output o_err_orphan
`ifdef MEM_ARB_STATS_EN
        , output o_stat_rd_grants, o_stat_wr_grants
`endif
    );

    modport slave (
        output i_rd_req, i_rd_addr, i_wr_have, i_wr_addr, i_wr_data,
        output i_mem_rdata_req_accepted, i_mem_wdata_accept,
        output i_mem_rdata, i_mem_rdata_valid, i_mem_rdata_lastword,
        input  o_rd_accept, o_rd_data, o_rd_valid, o_rd_lastword, o_wr_accept,
        input  o_mem_raddr, o_mem_rdata_req, o_mem_waddr, o_mem_wdata, o_mem_wdata_have,
        input  o_err_orphan
`ifdef MEM_ARB_STATS_EN
        , input o_stat_rd_grants, o_stat_wr_grants
`endif
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// rtl/mem_port_arbiter_rr_arbiter.sv - round-robin winner select with a registered priority pointer
module rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_BITS = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    output logic [PORT_BITS-1:0] winner,
    output logic                 any_req
);

    logic [PORT_BITS-1:0] ptr;
    logic [PORT_BITS-1:0] cand;
    logic                 found;
    int                   idx;

    // Scan from ptr upward with wrap; the first requester seen wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            cand = PORT_BITS'(idx);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign any_req = |req;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(winner) == NUM_PORTS - 1) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one DDR port between cache requesters; in-order tag queue steers read bursts back
// MEM_ARB_STATS_EN adds saturating per-port read/write grant counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS       = ARB_NUM_PORTS,
    parameter int PORT_BITS       = ARB_PORT_BITS,
    parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING,
    parameter int CNT_BITS        = ARB_CNT_BITS
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    mem_port_arbiter_if.master bus
);

    localparam int QBITS = tag_index_bits(MAX_OUTSTANDING);

    logic [PORT_BITS-1:0] rd_win, wr_win;
    logic                 rd_any, wr_any;
    logic                 rd_grant, wr_grant;
    logic                 q_full, q_empty;
    logic                 beat_ok, pop;
    logic [NUM_PORTS-1:0] rd_accept, wr_accept;

    logic [PORT_BITS-1:0] tag_mem [MAX_OUTSTANDING];
    logic [QBITS-1:0]     wr_idx, rd_idx;
    logic [QBITS:0]       count;
    logic [PORT_BITS-1:0] head;
    logic                 orphan;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PORT_BITS(PORT_BITS)) u_rd_arb (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .req       (bus.i_rd_req),
        .advance   (rd_grant),
        .winner    (rd_win),
        .any_req   (rd_any)
    );

    rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PORT_BITS(PORT_BITS)) u_wr_arb (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .req       (bus.i_wr_have),
        .advance   (wr_grant),
        .winner    (wr_win),
        .any_req   (wr_any)
    );

    // Full uses registered occupancy, so a same-cycle pop never frees a slot early.
    assign q_full   = (count == (QBITS+1)'(MAX_OUTSTANDING));
    assign q_empty  = (count == '0);
    assign rd_grant = rd_any && !q_full && bus.i_mem_rdata_req_accepted;
    assign wr_grant = wr_any && bus.i_mem_wdata_accept;

    assign rd_accept = rd_grant ? (NUM_PORTS'(1) << rd_win) : '0;
    assign wr_accept = wr_grant ? (NUM_PORTS'(1) << wr_win) : '0;

    assign bus.o_mem_rdata_req  = rd_any && !q_full;
    assign bus.o_rd_accept      = rd_accept;
    assign bus.o_mem_raddr      = rd_any ? bus.i_rd_addr[rd_win*MEM_ADDRBITS +: MEM_ADDRBITS] : '0;

    assign bus.o_mem_wdata_have = wr_any;
    assign bus.o_wr_accept      = wr_accept;
    assign bus.o_mem_waddr      = wr_any ? bus.i_wr_addr[wr_win*MEM_ADDRBITS +: MEM_ADDRBITS] : '0;
    assign bus.o_mem_wdata      = wr_any ? bus.i_wr_data[wr_win*MEM_WIDTH +: MEM_WIDTH] : '0;

    assign head    = tag_mem[rd_idx];
    assign beat_ok = bus.i_mem_rdata_valid && !q_empty;
    assign pop     = beat_ok && bus.i_mem_rdata_lastword;

    assign bus.o_rd_valid    = beat_ok ? (NUM_PORTS'(1) << head) : '0;
    assign bus.o_rd_data     = beat_ok ? bus.i_mem_rdata : '0;
    assign bus.o_rd_lastword = beat_ok && bus.i_mem_rdata_lastword;
    assign bus.o_err_orphan  = orphan;

    always_ff @(posedge i_clk) begin
        if (rd_grant) begin
            tag_mem[wr_idx] <= rd_win;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
            orphan <= 1'b0;
        end else begin
            if (rd_grant) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx <= rd_idx + 1'b1;
            end
            if (rd_grant && !pop) begin
                count <= count + 1'b1;
            end else if (!rd_grant && pop) begin
                count <= count - 1'b1;
            end
            if (bus.i_mem_rdata_valid && q_empty) begin
                orphan <= 1'b1;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stat
        logic [CNT_BITS-1:0] rd_cnt, wr_cnt;

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (rd_accept[p] && (rd_cnt != '1)) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
                if (wr_accept[p] && (wr_cnt != '1)) begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
        end

        assign bus.o_stat_rd_grants[p*CNT_BITS +: CNT_BITS] = rd_cnt;
        assign bus.o_stat_wr_grants[p*CNT_BITS +: CNT_BITS] = wr_cnt;
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a queue-based model
// MEM_ARB_STATS_EN enables the grant-counter saturation steps.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int NP = 4;
    localparam int AW = MEM_ADDRBITS;
    localparam int DW = MEM_WIDTH;
    localparam int MO = 4;
    localparam int CB = 16;

    logic i_clk = 1'b0;
    logic i_reset_n = 1'b0;
    always #5 i_clk = ~i_clk;

    mem_port_arbiter_if #(.NUM_PORTS(NP), .CNT_BITS(CB)) bus ();

    mem_port_arbiter #(.NUM_PORTS(NP), .PORT_BITS(2), .MAX_OUTSTANDING(MO), .CNT_BITS(CB)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [NP-1:0]    d_rd_req, d_wr_have;
    logic [NP*AW-1:0] d_rd_addr, d_wr_addr;
    logic [NP*DW-1:0] d_wr_data;
    logic             d_racc, d_wacc, d_valid, d_last;
    logic [DW-1:0]    d_rdata;

    int m_rd_ptr, m_wr_ptr;
    int q[$];
    bit m_orphan;

    logic [NP-1:0] last_rd_acc, last_wr_acc, last_rd_valid;
    logic          last_rdreq, last_lw;
    logic [AW-1:0] last_waddr;
    logic [DW-1:0] last_wdata;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(logic [NP-1:0] r, int ptr);
        for (int k = 0; k < NP; k++) begin
            if (r[(ptr + k) % NP]) return (ptr + k) % NP;
        end
        return -1;
    endfunction

    task automatic apply();
        bus.i_rd_req = d_rd_req;
        bus.i_rd_addr = d_rd_addr;
        bus.i_wr_have = d_wr_have;
        bus.i_wr_addr = d_wr_addr;
        bus.i_wr_data = d_wr_data;
        bus.i_mem_rdata_req_accepted = d_racc;
        bus.i_mem_wdata_accept = d_wacc;
        bus.i_mem_rdata = d_rdata;
        bus.i_mem_rdata_valid = d_valid;
        bus.i_mem_rdata_lastword = d_last;
    endtask

    task automatic idle();
        d_rd_req = '0; d_wr_have = '0; d_racc = 1'b0; d_wacc = 1'b0;
        d_valid = 1'b0; d_last = 1'b0; d_rdata = '0;
    endtask

    task automatic model_reset();
        q.delete();
        m_rd_ptr = 0;
        m_wr_ptr = 0;
        m_orphan = 1'b0;
    endtask

    task automatic cycle();
        int rwin, wwin;
        logic [NP-1:0] e_racc, e_wacc, e_rvalid;
        logic e_req, beat;
        @(negedge i_clk);
        apply();
        #1;
        rwin = rr_pick(d_rd_req, m_rd_ptr);
        wwin = rr_pick(d_wr_have, m_wr_ptr);
        e_req = (rwin >= 0) && (q.size() < MO);
        e_racc = '0;
        if (e_req && d_racc) e_racc[rwin] = 1'b1;
        e_wacc = '0;
        if ((wwin >= 0) && d_wacc) e_wacc[wwin] = 1'b1;
        beat = d_valid && (q.size() > 0);
        e_rvalid = '0;
        if (beat) e_rvalid[q[0]] = 1'b1;

        check("mem_rdata_req", bus.o_mem_rdata_req, e_req);
        check("rd_accept", bus.o_rd_accept, e_racc);
        if (rwin >= 0) check("mem_raddr", bus.o_mem_raddr, d_rd_addr[rwin*AW +: AW]);
        check("mem_wdata_have", bus.o_mem_wdata_have, wwin >= 0);
        check("wr_accept", bus.o_wr_accept, e_wacc);
        if (wwin >= 0) begin
            check("mem_waddr", bus.o_mem_waddr, d_wr_addr[wwin*AW +: AW]);
            check("mem_wdata", bus.o_mem_wdata, d_wr_data[wwin*DW +: DW]);
        end
        check("rd_valid", bus.o_rd_valid, e_rvalid);
        check("rd_lastword", bus.o_rd_lastword, beat && d_last);
        if (beat) check("rd_data", bus.o_rd_data, d_rdata);
        check("err_orphan", bus.o_err_orphan, m_orphan);

        last_rd_acc = bus.o_rd_accept;
        last_wr_acc = bus.o_wr_accept;
        last_rd_valid = bus.o_rd_valid;
        last_rdreq = bus.o_mem_rdata_req;
        last_lw = bus.o_rd_lastword;
        last_waddr = bus.o_mem_waddr;
        last_wdata = bus.o_mem_wdata;

        if (d_valid && (q.size() == 0)) m_orphan = 1'b1;
        if (beat && d_last) void'(q.pop_front());
        if (e_racc != '0) begin
            q.push_back(rwin);
            m_rd_ptr = (rwin + 1) % NP;
        end
        if (e_wacc != '0) m_wr_ptr = (wwin + 1) % NP;
    endtask

    // Return one full burst; hands back the o_rd_valid seen on its first beat.
    task automatic burst(output logic [NP-1:0] first_valid);
        first_valid = '0;
        for (int b = 0; b < ARB_BURST_BEATS; b++) begin
            d_valid = 1'b1;
            d_last = (b == ARB_BURST_BEATS - 1);
            d_rdata = DW'($urandom);
            cycle();
            if (b == 0) first_valid = last_rd_valid;
        end
        d_valid = 1'b0;
        d_last = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset_n = 1'b0;
        idle();
        apply();
        model_reset();
        #1;
        check("rst_rd_accept", bus.o_rd_accept, 0);
        check("rst_wr_accept", bus.o_wr_accept, 0);
        check("rst_rd_valid", bus.o_rd_valid, 0);
        check("rst_rdata_req", bus.o_mem_rdata_req, 0);
        check("rst_wdata_have", bus.o_mem_wdata_have, 0);
        check("rst_lastword", bus.o_rd_lastword, 0);
        check("rst_orphan", bus.o_err_orphan, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    logic [NP-1:0] fv;
    logic [NP-1:0] exp_w [7];
    logic [NP-1:0] exp_order [4];
    int beat_cnt;
    int guard;

    initial begin
        for (int p = 0; p < NP; p++) begin
            d_rd_addr[p*AW +: AW] = AW'(32'h100 + p);
            d_wr_addr[p*AW +: AW] = AW'(32'h200 + p);
            d_wr_data[p*DW +: DW] = DW'(32'hD0D0_0000 + p);
        end
        do_reset();

        // Ports 0 and 2 contend; grants alternate starting at port 0.
        d_rd_req = 4'b0101; d_racc = 1'b1;
        cycle(); check("rr_seq0", last_rd_acc, 4'b0001);
        cycle(); check("rr_seq1", last_rd_acc, 4'b0100);
        cycle(); check("rr_seq2", last_rd_acc, 4'b0001);
        cycle(); check("rr_seq3", last_rd_acc, 4'b0100);
        d_rd_req = '0;
        for (int n = 0; n < 4; n++) burst(fv);
        d_rd_req = 4'b1000;
        cycle(); check("rr_port3", last_rd_acc, 4'b1000);
        d_rd_req = 4'b1001;
        cycle(); check("rr_wrap0", last_rd_acc, 4'b0001);
        d_rd_req = '0;
        for (int n = 0; n < 2; n++) burst(fv);

        // Fill the tag queue, then see the full gate and in-order return.
        d_rd_req = 4'b0010; cycle();
        d_rd_req = 4'b1000; cycle();
        d_rd_req = 4'b0001; cycle();
        d_rd_req = 4'b0100; cycle();
        d_rd_req = 4'b0010;
        cycle(); check("full_no_req", last_rdreq, 1'b0);
        check("full_no_acc", last_rd_acc, 4'b0000);
        for (int b = 0; b < ARB_BURST_BEATS; b++) begin
            d_valid = 1'b1;
            d_last = (b == ARB_BURST_BEATS - 1);
            d_rdata = DW'($urandom);
            cycle();
            if (b == 0) check("ret_first_p1", last_rd_valid, 4'b0010);
        end
        check("pop_beat_lw", last_lw, 1'b1);
        check("pop_beat_no_acc", last_rd_acc, 4'b0000);
        d_valid = 1'b0; d_last = 1'b0;
        cycle(); check("after_pop_acc", last_rd_acc, 4'b0010);
        d_rd_req = 4'b0001;
        cycle(); check("refull_no_req", last_rdreq, 1'b0);
        d_rd_req = '0;
        exp_order[0] = 4'b1000; exp_order[1] = 4'b0001;
        exp_order[2] = 4'b0100; exp_order[3] = 4'b0010;
        for (int n = 0; n < 4; n++) begin
            burst(fv);
            check("ret_order", fv, exp_order[n]);
        end

        // Writes: all ports pending, accept toggling.
        exp_w[0] = 4'b0001; exp_w[1] = 4'b0000; exp_w[2] = 4'b0010; exp_w[3] = 4'b0000;
        exp_w[4] = 4'b0100; exp_w[5] = 4'b0000; exp_w[6] = 4'b1000;
        d_wr_have = 4'b1111;
        for (int i = 0; i < 7; i++) begin
            d_wacc = (i % 2 == 0);
            cycle();
            check("wr_seq", last_wr_acc, exp_w[i]);
            if (i % 2 == 0) begin
                check("wr_seq_addr", last_waddr, AW'(32'h200 + i/2));
                check("wr_seq_data", last_wdata, DW'(32'hD0D0_0000 + i/2));
            end
        end
        idle();

        // Randomized traffic with in-order burst returns.
        beat_cnt = 0;
        for (int c = 0; c < 1500; c++) begin
            d_rd_req = NP'($urandom);
            d_wr_have = NP'($urandom);
            d_racc = $urandom_range(0, 1);
            d_wacc = $urandom_range(0, 1);
            for (int p = 0; p < NP; p++) begin
                d_rd_addr[p*AW +: AW] = AW'($urandom);
                d_wr_addr[p*AW +: AW] = AW'($urandom);
                d_wr_data[p*DW +: DW] = DW'($urandom);
            end
            d_valid = (q.size() > 0) && ($urandom_range(0, 3) != 0);
            d_last = d_valid && (beat_cnt == ARB_BURST_BEATS - 1);
            d_rdata = DW'($urandom);
            cycle();
            if (d_valid) beat_cnt = (beat_cnt + 1) % ARB_BURST_BEATS;
        end
        idle();
        guard = 0;
        while ((q.size() > 0) && (guard < 200)) begin
            d_valid = 1'b1;
            d_last = (beat_cnt == ARB_BURST_BEATS - 1);
            cycle();
            beat_cnt = (beat_cnt + 1) % ARB_BURST_BEATS;
            guard++;
        end
        d_valid = 1'b0; d_last = 1'b0;
        check("drain_done", guard < 200, 1'b1);

        // Orphan beat with nothing outstanding.
        d_valid = 1'b1; d_last = 1'b0;
        cycle(); check("orphan_no_valid", last_rd_valid, 4'b0000);
        idle();
        cycle(); check("orphan_set", bus.o_err_orphan, 1'b1);

        // Reset in the middle of a burst; leftover beats are orphans.
        do_reset();
        d_rd_req = 4'b0100; d_racc = 1'b1;
        cycle(); check("pre_rst_acc", last_rd_acc, 4'b0100);
        idle();
        for (int b = 0; b < 3; b++) begin
            d_valid = 1'b1; d_rdata = DW'($urandom);
            cycle();
        end
        do_reset();
        for (int b = 3; b < ARB_BURST_BEATS; b++) begin
            d_valid = 1'b1; d_last = (b == ARB_BURST_BEATS - 1);
            cycle();
        end
        idle();
        cycle(); check("post_rst_orphan", bus.o_err_orphan, 1'b1);

`ifdef MEM_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 70000; i++) begin
            @(negedge i_clk);
            d_rd_req = 4'b0001; d_racc = 1'b1;
            d_valid = (i > 0); d_last = (i > 0);
            apply();
        end
        @(negedge i_clk);
        idle();
        apply();
        #1;
        check("stat_rd0_sat", bus.o_stat_rd_grants[0 +: CB], 16'hFFFF);
        for (int p = 1; p < NP; p++) check("stat_rd_other", bus.o_stat_rd_grants[p*CB +: CB], 0);
        for (int p = 0; p < NP; p++) check("stat_wr_zero", bus.o_stat_wr_grants[p*CB +: CB], 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
